// File: rtl/fetch_ctl.sv
// fetch_ctl: instruction-fetch controller with req/ack memory handshake and 2-entry decode queue
module fetch_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_addr,
  output logic        pc_adv,
  input  logic        redirect,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        dec_ready,
  output logic        err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALTED} state_t;
  state_t      state, nxt;
  logic        halt_seen;
  logic [15:0] req_addr;
  logic [1:0]  count;
  logic        wptr, rptr;
  logic [15:0] qd [2];
  logic [15:0] qa [2];
  logic        issue, push, pop;
  // state register, latched request address and sticky halt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      req_addr  <= '0;
      halt_seen <= 1'b0;
    end else begin
      state <= nxt;
      if (issue) req_addr <= pc_addr;
      if (halt) halt_seen <= 1'b1;
    end
  end
  // next-state: a redirect while waiting turns the outstanding request into a discard
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = halt_seen ? S_HALTED : issue ? S_WAIT : S_IDLE;
      S_WAIT:  nxt = imem_ack ? S_IDLE : redirect ? S_DROP : S_WAIT;
      S_DROP:  nxt = imem_ack ? S_IDLE : S_DROP;
      default: nxt = S_HALTED;
    endcase
  end
  // outputs decoded from state plus the same-cycle ack/redirect
  always_comb begin
    issue    = (state == S_IDLE) && !halt_seen && !redirect && (count < 2'd2);
    imem_req = (state == S_WAIT) || (state == S_DROP);
    push     = (state == S_WAIT) && imem_ack && !redirect;
    pc_adv   = push;
    err      = imem_ack && ((state == S_IDLE) || (state == S_HALTED));
    pop      = inst_valid && dec_ready;
  end
  // circular 2-entry queue; redirect empties it and overrides any push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      qd[0] <= '0;
      qd[1] <= '0;
      qa[0] <= '0;
      qa[1] <= '0;
    end else if (redirect) begin
      count <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) begin
        qd[wptr] <= imem_data;
        qa[wptr] <= req_addr;
        wptr     <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign imem_addr  = req_addr;
  assign inst_valid = (count != 2'd0);
  assign inst       = qd[rptr];
  assign inst_pc    = qa[rptr];
endmodule

// File: tb/tb_fetch_ctl.sv
// tb_fetch_ctl: directed stimulus with a scoreboard queue of expected {inst, inst_pc} pops
module tb_fetch_ctl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_addr = '0;
  logic        pc_adv;
  logic        redirect = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        dec_ready = 1'b0;
  logic        err;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  fetch_ctl dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_adv(pc_adv), .redirect(redirect),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .dec_ready(dec_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // monitor: every accepted queue head must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && inst_valid && dec_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", {inst, inst_pc}, 32'hxxxx_xxxx);
      else check("pop", {inst, inst_pc}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) next();
    samp();
    check("rst_outs", {imem_req, pc_adv, inst_valid, err}, 4'b0000);
    check("rst_data", {imem_addr, inst}, 32'h0);
    check("rst_inst_pc", {16'h0, inst_pc}, 32'h0);
    // cycle 0: leave reset, memory acks one cycle after req
    next(); rst = 1'b1;
    samp(); check("c0_req", imem_req, 1'b0);
    next(); samp(); check("c1_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
    next(); imem_ack = 1'b1; imem_data = 16'h1234; exp_q.push_back({16'h1234, 16'h0000});
    samp(); check("c2_pc_adv", pc_adv, 1'b1);
    next(); imem_ack = 1'b0; pc_addr = 16'h0002;
    samp(); check("c3_head", {inst_valid, inst, inst_pc}, {1'b1, 16'h1234, 16'h0000});
    check("c3_req", imem_req, 1'b0);
    next(); samp(); check("c4_req", {imem_req, imem_addr}, {1'b1, 16'h0002});
    imem_ack = 1'b1; imem_data = 16'h5678; exp_q.push_back({16'h5678, 16'h0002});
    next(); imem_ack = 1'b0;
    samp(); check("c5_full_noreq", imem_req, 1'b0);
    next(); pc_addr = 16'h0004; dec_ready = 1'b1;
    samp(); check("c6_full_noreq", imem_req, 1'b0);
    next(); samp(); check("c7_req", imem_req, 1'b0);
    next(); dec_ready = 1'b0;
    samp(); check("c8_req", {imem_req, imem_addr}, {1'b1, 16'h0004});
    imem_ack = 1'b1; imem_data = 16'h1111; exp_q.push_back({16'h1111, 16'h0004});
    next(); imem_ack = 1'b0; pc_addr = 16'h0006;
    samp(); check("c9_valid", inst_valid, 1'b1);
    // redirect while waiting: response 3 cycles later is discarded
    next(); samp(); check("c10_req", {imem_req, imem_addr}, {1'b1, 16'h0006});
    redirect = 1'b1; exp_q.delete();
    next(); redirect = 1'b0; pc_addr = 16'h0100;
    samp(); check("c11_drop", {inst_valid, imem_req, imem_addr}, {1'b0, 1'b1, 16'h0006});
    next(); samp(); check("c12_drop_req", imem_req, 1'b1);
    next(); imem_ack = 1'b1; imem_data = 16'hDEAD;
    samp(); check("c13_no_adv", {pc_adv, err}, 2'b00);
    next(); imem_ack = 1'b0;
    samp(); check("c14_idle", {inst_valid, imem_req}, 2'b00);
    next(); samp(); check("c15_newaddr", {imem_req, imem_addr}, {1'b1, 16'h0100});
    imem_ack = 1'b1; imem_data = 16'h2222; exp_q.push_back({16'h2222, 16'h0100});
    next(); imem_ack = 1'b0; pc_addr = 16'h0200;
    // redirect and ack together
    next(); samp(); check("c17_req", {imem_req, imem_addr}, {1'b1, 16'h0200});
    imem_ack = 1'b1; imem_data = 16'h3333; redirect = 1'b1; exp_q.delete();
    samp(); check("c17_adv", pc_adv, 1'b0);
    next(); imem_ack = 1'b0; redirect = 1'b0; pc_addr = 16'h0300;
    samp(); check("c18_flush", {inst_valid, imem_req}, 2'b00);
    // halt during wait: outstanding completes then no more requests
    next(); samp(); check("c19_req", {imem_req, imem_addr}, {1'b1, 16'h0300});
    halt = 1'b1;
    next(); halt = 1'b0; imem_ack = 1'b1; imem_data = 16'h4444;
    exp_q.push_back({16'h4444, 16'h0300});
    samp(); check("c20_adv", pc_adv, 1'b1);
    next(); imem_ack = 1'b0;
    samp(); check("c21_noreq", imem_req, 1'b0);
    next(); samp(); check("c22_halted", {imem_req, inst_valid, inst}, {1'b0, 1'b1, 16'h4444});
    next(); dec_ready = 1'b1;
    next(); dec_ready = 1'b0;
    samp(); check("c24_drained", {inst_valid, imem_req}, 2'b00);
    next(); imem_ack = 1'b1; imem_data = 16'hBEEF;
    samp(); check("c25_err_halted", {err, pc_adv}, 2'b10);
    next(); imem_ack = 1'b0;
    samp(); check("c26_err_clr", {err, imem_req, inst_valid}, 3'b000);
    // reset clears halt; stray ack in IDLE with a non-empty queue
    next(); rst = 1'b0;
    next(); rst = 1'b1; pc_addr = 16'h0400;
    next(); samp(); check("r1_req", {imem_req, imem_addr}, {1'b1, 16'h0400});
    imem_ack = 1'b1; imem_data = 16'h5555; exp_q.push_back({16'h5555, 16'h0400});
    next(); imem_data = 16'h9999; pc_addr = 16'h0402;
    samp(); check("r2_err", {err, pc_adv}, 2'b10);
    next(); imem_ack = 1'b0;
    samp(); check("r3_head", {inst_valid, inst, inst_pc}, {1'b1, 16'h5555, 16'h0400});
    check("r3_req", {imem_req, imem_addr}, {1'b1, 16'h0402});
    imem_ack = 1'b1; imem_data = 16'h6666; exp_q.push_back({16'h6666, 16'h0402});
    next(); imem_ack = 1'b0; dec_ready = 1'b1; pc_addr = 16'h0404;
    next(); next(); dec_ready = 1'b0;
    samp(); check("r6_empty", inst_valid, 1'b0);
    // async reset abandons an outstanding request immediately
    next(); samp(); check("r7_req", {imem_req, imem_addr}, {1'b1, 16'h0404});
    rst = 1'b0; #1;
    check("r7_async", {imem_req, imem_addr}, {1'b0, 16'h0000});
    next(); rst = 1'b1; imem_ack = 1'b1;
    samp(); check("r8_stray", err, 1'b1);
    next(); imem_ack = 1'b0;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
